// File: rtl/ppu_clk_pkg.sv
// ppu_clk_pkg: shared types and sizing helpers for the PPU clock-control slice
package ppu_clk_pkg;
    typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL} pll_sup_state_t;
    localparam int LOSS_CNT_W = 8;
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m > 1 ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/bit_sync2.sv
// bit_sync2: two-flop synchronizer for a single asynchronous level
module bit_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta, r_q;
    // shift the raw level through two flops; both clear on reset
    always_ff @(posedge i_clk)
        if (i_rst) {r_q, r_meta} <= 2'b00;
        else {r_q, r_meta} <= {r_meta, i_d};
    assign o_q = r_q;
endmodule

// File: rtl/ppu_pll_supervisor.sv
// ppu_pll_supervisor: sequences the PLL reset, qualifies lock and gates the PPU reset
module ppu_pll_supervisor
    import ppu_clk_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7
) (
    input  logic                               i_refclk,
    input  logic                               i_rst,
    input  logic                               i_pll_locked,
    input  logic                               i_restart,
    output logic                               o_pll_rst,
    output logic                               o_ppu_rst,
    output logic                               o_ready,
    output logic                               o_fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   o_retry_count,
    output logic [LOSS_CNT_W-1:0]              o_lock_loss_count
);
    localparam int CW  = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int RCW = $clog2(MAX_RETRIES+1);
    pll_sup_state_t r_state, w_next;
    logic [CW-1:0]  r_cnt;
    logic           w_locked_s, w_timeout, w_retry_max;
    bit_sync2 u_lock_sync (
        .i_clk (i_refclk),
        .i_rst (i_rst),
        .i_d   (i_pll_locked),
        .o_q   (w_locked_s)
    );
    // next-state decode; restart overrides every other transition
    always_comb begin
        w_timeout   = r_cnt == CW'(LOCK_TIMEOUT_CYCLES-1);
        w_retry_max = o_retry_count == RCW'(MAX_RETRIES);
        w_next      = r_state;
        if (i_restart) w_next = RESET_PLL;
        else case (r_state)
            RESET_PLL: w_next = r_cnt == CW'(RST_PULSE_CYCLES-1) ? WAIT_LOCK : RESET_PLL;
            WAIT_LOCK: w_next = w_locked_s ? STABLE : !w_timeout ? WAIT_LOCK : w_retry_max ? FAIL : RESET_PLL;
            STABLE:    w_next = !w_locked_s ? WAIT_LOCK : r_cnt == CW'(LOCK_STABLE_CYCLES-1) ? RUN : STABLE;
            RUN:       w_next = w_locked_s ? RUN : RESET_PLL;
            FAIL:      w_next = FAIL;
            default:   w_next = RESET_PLL;
        endcase
    end
    // state, per-state cycle counter and outputs decoded from the next state
    always_ff @(posedge i_refclk)
        if (i_rst) begin
            r_state   <= RESET_PLL;
            r_cnt     <= '0;
            o_pll_rst <= 1'b1;
            o_ppu_rst <= 1'b1;
            o_ready   <= 1'b0;
            o_fail    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (w_next != r_state || i_restart) ? '0 : r_cnt + CW'(1);
            o_pll_rst <= w_next == RESET_PLL || w_next == FAIL;
            o_ppu_rst <= w_next != RUN;
            o_ready   <= w_next == RUN;
            o_fail    <= w_next == FAIL;
        end
    // retry and lock-loss bookkeeping; a drop coincident with restart is not counted
    always_ff @(posedge i_refclk)
        if (i_rst) begin
            o_retry_count     <= '0;
            o_lock_loss_count <= '0;
        end else begin
            if (i_restart || (w_next == RUN && r_state != RUN))
                o_retry_count <= '0;
            else if (r_state == WAIT_LOCK && w_next == RESET_PLL)
                o_retry_count <= o_retry_count + RCW'(1);
            if (r_state == RUN && !w_locked_s && !i_restart && o_lock_loss_count != '1)
                o_lock_loss_count <= o_lock_loss_count + LOSS_CNT_W'(1);
        end
endmodule

// File: tb/tb_ppu_pll_supervisor.sv
// tb_ppu_pll_supervisor: scoreboard bench for the PLL supervisor sequencing
module tb_ppu_pll_supervisor;
    localparam int RP = 4, TO = 20, ST = 8, MR = 2;
    logic       clk = 1'b0, rst = 1'b1, locked = 1'b0, restart = 1'b0;
    logic       pll_rst, ppu_rst, ready, fail;
    logic [1:0] rc;
    logic [7:0] llc;
    int         cyc = 0, errors = 0, checks = 0, llc_m = 0;
    typedef struct {int at; string tag; logic [13:0] v;} exp_t;
    exp_t q[$];

    ppu_pll_supervisor #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (ST),
        .MAX_RETRIES         (MR)
    ) dut (
        .i_refclk          (clk),
        .i_rst             (rst),
        .i_pll_locked      (locked),
        .i_restart         (restart),
        .o_pll_rst         (pll_rst),
        .o_ppu_rst         (ppu_rst),
        .o_ready           (ready),
        .o_fail            (fail),
        .o_retry_count     (rc),
        .o_lock_loss_count (llc)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [13:0] v(input bit pr, input bit pp, input bit rd, input bit fl, input int r, input int lc);
        return {pr, pp, rd, fl, 2'(r), 8'(lc)};
    endfunction

    task automatic expect_at(input int at, input string tag, input logic [13:0] e);
        q.push_back('{at, tag, e});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk)
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].at == cyc) begin
                check(q[i].tag, 32'({pll_rst, ppu_rst, ready, fail, rc, llc}), 32'(q[i].v));
                q.delete(i);
            end

    task automatic loss(input bit with_rs);
        int l  = cyc;
        int nc = with_rs ? llc_m : (llc_m == 255 ? 255 : llc_m + 1);
        expect_at(l + 2,  "run_hold",     v(0, 0, 1, 0, 0, llc_m));
        expect_at(l + 3,  with_rs ? "rs_drop" : "loss", v(1, 1, 0, 0, 0, nc));
        expect_at(l + 7,  "relock_pulse", v(0, 1, 0, 0, 0, nc));
        expect_at(l + 15, "relock_wait",  v(0, 1, 0, 0, 0, nc));
        expect_at(l + 16, "relock_run",   v(0, 0, 1, 0, 0, nc));
        locked = 1'b0;
        tick(2);
        restart = with_rs;
        tick(1);
        restart = 1'b0;
        locked  = 1'b1;
        tick(13);
        llc_m = nc;
    endtask

    initial begin
        int r0, s, t;
        tick(3);
        expect_at(cyc, "reset", v(1, 1, 0, 0, 0, 0));
        r0 = cyc;
        expect_at(r0 + 3,  "pulse_hi",  v(1, 1, 0, 0, 0, 0));
        expect_at(r0 + 4,  "pulse_lo",  v(0, 1, 0, 0, 0, 0));
        expect_at(r0 + 13, "pre_ready", v(0, 1, 0, 0, 0, 0));
        expect_at(r0 + 14, "ready",     v(0, 0, 1, 0, 0, 0));
        rst = 1'b0;
        tick(3);
        locked = 1'b1;
        tick(11);
        loss(1'b0);
        loss(1'b1);
        s = cyc;
        expect_at(s + 1,  "g_restart", v(1, 1, 0, 0, 0, llc_m));
        expect_at(s + 14, "g_noready", v(0, 1, 0, 0, 0, llc_m));
        expect_at(s + 19, "g_pre",     v(0, 1, 0, 0, 0, llc_m));
        expect_at(s + 20, "g_ready",   v(0, 0, 1, 0, 0, llc_m));
        restart = 1'b1;
        locked  = 1'b0;
        tick(1);
        restart = 1'b0;
        tick(2);
        locked = 1'b1;
        tick(5);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(11);
        for (int k = 0; k < 300; k++) loss(1'b0);
        t = cyc;
        expect_at(t + 1,   "to_p1",     v(1, 1, 0, 0, 0, llc_m));
        expect_at(t + 4,   "to_p1_end", v(1, 1, 0, 0, 0, llc_m));
        expect_at(t + 5,   "to_w1",     v(0, 1, 0, 0, 0, llc_m));
        expect_at(t + 24,  "to_w1_end", v(0, 1, 0, 0, 0, llc_m));
        expect_at(t + 25,  "to_p2",     v(1, 1, 0, 0, 1, llc_m));
        expect_at(t + 28,  "to_p2_end", v(1, 1, 0, 0, 1, llc_m));
        expect_at(t + 29,  "to_w2",     v(0, 1, 0, 0, 1, llc_m));
        expect_at(t + 48,  "to_w2_end", v(0, 1, 0, 0, 1, llc_m));
        expect_at(t + 49,  "to_p3",     v(1, 1, 0, 0, 2, llc_m));
        expect_at(t + 53,  "to_w3",     v(0, 1, 0, 0, 2, llc_m));
        expect_at(t + 72,  "to_w3_end", v(0, 1, 0, 0, 2, llc_m));
        expect_at(t + 73,  "fail",      v(1, 1, 0, 1, 2, llc_m));
        expect_at(t + 100, "fail_hold", v(1, 1, 0, 1, 2, llc_m));
        expect_at(t + 101, "rs_fail",   v(1, 1, 0, 0, 0, llc_m));
        expect_at(t + 104, "rs_p_end",  v(1, 1, 0, 0, 0, llc_m));
        expect_at(t + 105, "rs_w",      v(0, 1, 0, 0, 0, llc_m));
        expect_at(t + 108, "stable",    v(0, 1, 0, 0, 0, llc_m));
        expect_at(t + 109, "rst_mid",   v(1, 1, 0, 0, 0, 0));
        restart = 1'b1;
        locked  = 1'b0;
        tick(1);
        restart = 1'b0;
        tick(99);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(3);
        locked = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(3);
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
